// File: rtl/if_prefetch_unit_pkg.sv
// ============================================================================
// if_prefetch_unit_pkg : shared types and constants for the instruction prefetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package if_prefetch_unit_pkg;

  localparam logic [31:0] C_NOP     = 32'h0000_0013;
  localparam int unsigned C_XLEN    = 32;
  localparam int unsigned C_ENTRY_W = 1 + 2 * C_XLEN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic              err;
    logic [C_XLEN-1:0] pc;
    logic [C_XLEN-1:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_prefetch_unit_fetch_queue.sv
// ============================================================================
// if_prefetch_unit_fetch_queue : show-ahead FIFO with synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module if_prefetch_unit_fetch_queue
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = C_ENTRY_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned    C_AW   = $clog2(DEPTH);
  localparam int unsigned    C_CW   = $clog2(DEPTH+1);
  localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [C_AW-1:0]  wr_ptr_q;
  logic [C_AW-1:0]  rd_ptr_q;
  logic [C_CW-1:0]  count_q;
  logic [C_CW-1:0]  count_d;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (count_q == C_FULL);
  assign w_empty = (count_q == '0);
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign w_pop   = pop_i && !w_empty && !clr_i;
  assign w_push  = push_i && !clr_i && (!w_full || w_pop);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = w_empty;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/if_prefetch_unit.sv
// ============================================================================
// if_prefetch_unit : Wishbone-classic sequential instruction prefetch front end
// Rev 1.0
// ============================================================================
`default_nettype none

module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] iaddr_o,
  output logic [31:0] idat_o,
  output logic [3:0]  isel_o,
  output logic        icyc_o,
  output logic        istb_o,
  output logic        iwe_o,
  input  logic [31:0] idat_i,
  input  logic        iack_i,
  input  logic        ierr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        xint_o
);

  localparam int unsigned     C_CW    = $clog2(DEPTH+1);
  localparam logic [C_CW:0]   C_DEPTH = (C_CW+1)'(DEPTH);

  logic [1:0]      state_q,    state_d;
  logic [31:0]     fpc_q,      fpc_d;
  logic [31:0]     drain_pc_q, drain_pc_d;
  logic            halted_q,   halted_d;

  logic            w_push;
  logic            w_clr;
  logic            w_pop;
  logic            w_valid;
  logic            w_empty;
  logic            w_resp;
  logic [C_CW-1:0] w_count;
  logic [C_CW:0]   w_cnt_ap;
  fq_entry_t       w_push_ent;
  fq_entry_t       w_head;

  assign w_valid  = !w_empty;
  assign w_pop    = w_valid && ready_i;
  assign w_resp   = iack_i || ierr_i;
  // Occupancy once this cycle's pop (if any) has left; credit is judged against it.
  assign w_cnt_ap = {1'b0, w_count} - {{C_CW{1'b0}}, w_pop};

  always_comb begin
    state_d         = state_q;
    fpc_d           = fpc_q;
    drain_pc_d      = drain_pc_q;
    halted_d        = halted_q;
    w_push          = 1'b0;
    w_clr           = 1'b0;
    w_push_ent.err  = 1'b0;
    w_push_ent.pc   = fpc_q;
    w_push_ent.inst = idat_i;

    case (state_q)
      ST_IDLE: begin
        if (!halted_q && (w_cnt_ap < C_DEPTH)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (iack_i) begin
          w_push  = 1'b1;
          fpc_d   = fpc_q + 32'd4;
          state_d = ((w_cnt_ap + 1'b1) < C_DEPTH) ? ST_REQ : ST_IDLE;
        end else if (ierr_i) begin
          w_push          = 1'b1;
          w_push_ent.err  = 1'b1;
          w_push_ent.inst = C_NOP;
          halted_d        = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_resp) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything: the in-flight word belongs to the old stream.
    if (redirect_i) begin
      w_clr    = 1'b1;
      w_push   = 1'b0;
      halted_d = 1'b0;
      fpc_d    = align_pc(redirect_pc_i);
      if (state_q == ST_REQ && !w_resp) begin
        state_d    = ST_DRAIN;
        drain_pc_d = fpc_q;
      end else if (state_q == ST_DRAIN && !w_resp) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fpc_q      <= RESET_PC;
      drain_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      drain_pc_q <= drain_pc_d;
      halted_q   <= halted_d;
    end
  end

  if_prefetch_unit_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_clr),
    .push_i  (w_push),
    .data_i  (w_push_ent),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign icyc_o  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign istb_o  = icyc_o;
  assign iaddr_o = (state_q == ST_DRAIN) ? drain_pc_q : fpc_q;
  assign idat_o  = 32'h0000_0000;
  assign isel_o  = 4'b1111;
  assign iwe_o   = 1'b0;

  // Head fields are masked while empty so stale RAM contents never reach decode.
  assign valid_o = w_valid;
  assign inst_o  = w_valid ? w_head.inst : 32'h0000_0000;
  assign pc_o    = w_valid ? w_head.pc   : 32'h0000_0000;
  assign xint_o  = w_valid && w_head.err;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
// ============================================================================
// tb_if_prefetch_unit : directed vector table plus randomized run against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] iaddr_o;
  logic [31:0] idat_o;
  logic [3:0]  isel_o;
  logic        icyc_o;
  logic        istb_o;
  logic        iwe_o;
  logic [31:0] idat_i;
  logic        iack_i;
  logic        ierr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        xint_o;

  always #5 clk = ~clk;

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .iaddr_o(iaddr_o), .idat_o(idat_o), .isel_o(isel_o), .icyc_o(icyc_o),
    .istb_o(istb_o), .iwe_o(iwe_o), .idat_i(idat_i), .iack_i(iack_i),
    .ierr_i(ierr_i), .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
    .pc_o(pc_o), .xint_o(xint_o)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Memory image seen by the bus slave: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input bit r, input bit red, input logic [31:0] rpc,
                       input bit rdy, input bit ack, input bit err);
    rst           = r;
    redirect_i    = red;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    iack_i        = ack;
    ierr_i        = err;
    idat_i        = mem_word(iaddr_o);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst, red;
    logic [31:0] rpc;
    bit          rdy, ack, err;
    bit          e_cyc;
    logic [31:0] e_addr;
    bit          e_val;
    logic [31:0] e_pc;
    bit          e_xint;
  } vec_t;

  function automatic vec_t mk(int r, int red, logic [31:0] rpc, int rdy, int ack, int err,
                              int ecyc, logic [31:0] eaddr, int ev, logic [31:0] epc, int ex);
    vec_t v;
    v.rst = (r != 0);  v.red = (red != 0); v.rpc = rpc;
    v.rdy = (rdy != 0); v.ack = (ack != 0); v.err = (err != 0);
    v.e_cyc = (ecyc != 0); v.e_addr = eaddr; v.e_val = (ev != 0);
    v.e_pc = epc; v.e_xint = (ex != 0);
    return v;
  endfunction

  // Reference model: fetch stream as a queue of words plus a bus-open flag.
  typedef struct packed { bit err; logic [31:0] pc; logic [31:0] inst; } m_ent_t;
  m_ent_t      m_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_hold;
  bit          m_halt, m_busy, m_disc, m_known;

  task automatic model_step(input bit r, input bit red, input logic [31:0] rpc,
                            input bit rdy, input bit ack, input bit err);
    bit     resp;
    m_ent_t e;
    if (r) begin
      m_fpc = RESET_PC; m_halt = 0; m_busy = 0; m_disc = 0; m_q.delete(); m_known = 1;
      return;
    end
    if (!m_known) return;
    resp = m_busy && (ack || err);
    if (red) begin
      m_q.delete();
      m_halt = 0;
      if (m_busy && !resp) begin
        if (!m_disc) m_hold = m_fpc;
        m_disc = 1;
      end else begin
        m_busy = 0; m_disc = 0;
      end
      m_fpc = rpc & 32'hFFFF_FFFC;
      return;
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (m_busy && m_disc) begin
      if (resp) begin m_busy = 0; m_disc = 0; end
    end else if (m_busy) begin
      if (ack) begin
        e.err = 0; e.pc = m_fpc; e.inst = mem_word(m_fpc);
        m_q.push_back(e);
        m_fpc  = m_fpc + 32'd4;
        m_busy = (m_q.size() < DEPTH);
      end else if (err) begin
        e.err = 1; e.pc = m_fpc; e.inst = NOP;
        m_q.push_back(e);
        m_halt = 1; m_busy = 0;
      end
    end else if (!m_halt && m_q.size() < DEPTH) begin
      m_busy = 1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int acks;
    bit found;

    //         rst red rpc           rdy ack err | cyc addr          val pc            xint
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,   0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h4,         1, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h8,         1, 32'h4,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0,   1, 32'hC,         1, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0,   1, 32'h10,        1, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0,   1, 32'h14,        1, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,   0, 32'h18,        1, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h18,        1, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,   1, 32'h18,        1, 32'hC,         0));
    vecs.push_back(mk(0, 1, 32'h103,       0, 0, 0,   1, 32'h18,        1, 32'hC,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   1, 32'h18,        0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h18,        0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h100,       0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h100,       0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h104,       1, 32'h100,       0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 1,   1, 32'h108,       1, 32'h104,       0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,   0, 32'h108,       1, 32'h108,       1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h108,       1, 32'h108,       1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h108,       0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 32'h40,        1, 0, 0,   0, 32'h108,       0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h40,        0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h40,        0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 32'h200,       1, 1, 0,   1, 32'h44,        1, 32'h40,        0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'h200,       0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   1, 32'h200,       0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0,   1, 32'h200,       0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,   1, 32'h4,         1, 32'h0,         0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 1, 0, 0,   1, 32'h4,         1, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'h4,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   0, 32'hFFFF_FFF8, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'hFFFF_FFF8, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,   1, 32'h0,         1, 32'hFFFF_FFFC, 0));

    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    iack_i = 1'b0; ierr_i = 1'b0; idat_i = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    chk("idat_o", 0, idat_o, 32'h0);
    chk("isel_o", 0, {28'h0, isel_o}, 32'hF);
    chk("iwe_o",  0, {31'h0, iwe_o},  32'h0);

    foreach (vecs[i]) begin
      vec_t v;
      logic [31:0] e_inst;
      v = vecs[i];
      e_inst = !v.e_val ? 32'h0 : (v.e_xint ? NOP : mem_word(v.e_pc));
      drive(v.rst, v.red, v.rpc, v.rdy, v.ack, v.err);
      chk("cyc",   i, {31'h0, icyc_o},  {31'h0, v.e_cyc});
      chk("stb",   i, {31'h0, istb_o},  {31'h0, v.e_cyc});
      chk("addr",  i, iaddr_o,          v.e_addr);
      chk("valid", i, {31'h0, valid_o}, {31'h0, v.e_val});
      chk("pc",    i, pc_o,             v.e_val ? v.e_pc : 32'h0);
      chk("inst",  i, inst_o,           e_inst);
      chk("xint",  i, {31'h0, xint_o},  {31'h0, v.e_xint});
      step();
    end

    // Decode stalled: the queue must take exactly DEPTH words, then the bus goes quiet.
    drive(1, 0, 32'h0, 0, 0, 0);
    step();
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 32'h0, 0, icyc_o, 0);
      if (icyc_o) acks++;
      step();
    end
    chk("fill_acks",  0, 32'(acks), 32'(DEPTH));
    chk("fill_cyc",   0, {31'h0, icyc_o},  32'h0);
    chk("fill_valid", 0, {31'h0, valid_o}, 32'h1);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      drive(0, 0, 32'h0, 1, 0, 0);
      step();
      if (icyc_o) found = 1;
    end
    chk("resume_seen", 0, {31'h0, found}, 32'h1);
    chk("resume_addr", 0, iaddr_o, 32'(DEPTH * 4));

    // Randomized traffic against the model.
    m_known = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit          r, red, rdy, ack, err;
      logic [31:0] rpc;
      int          k;
      if (m_known) begin
        chk("r_cyc",   cyc, {31'h0, icyc_o},  {31'h0, m_busy});
        chk("r_addr",  cyc, iaddr_o,          m_disc ? m_hold : m_fpc);
        chk("r_valid", cyc, {31'h0, valid_o}, {31'h0, (m_q.size() > 0)});
        chk("r_pc",    cyc, pc_o,             (m_q.size() > 0) ? m_q[0].pc : 32'h0);
        chk("r_inst",  cyc, inst_o,           (m_q.size() > 0) ? m_q[0].inst : 32'h0);
        chk("r_xint",  cyc, {31'h0, xint_o},  {31'h0, (m_q.size() > 0) && m_q[0].err});
      end
      r   = (cyc == 0) || ($urandom_range(0, 299) == 0);
      red = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 9) < 6);
      k   = $urandom_range(0, 99);
      ack = icyc_o ? (k < 55) : (k < 2);
      err = icyc_o && (k >= 55) && (k < 59);
      drive(r, red, rpc, rdy, ack, err);
      model_step(r, red, rpc, rdy, ack, err);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
